// File: rtl/ntru_pkg.sv
// Shared NTRU/HRSS datapath types: trit encoding, packer FSM states and the
// power-of-three helper used to build constant weight tables at elaboration.
package ntru_pkg;

   typedef logic [1:0] trit_t;

   localparam trit_t TRIT_ZERO = 2'd0;
   localparam trit_t TRIT_ONE  = 2'd1;
   localparam trit_t TRIT_TWO  = 2'd2;

   typedef enum logic {
      ACCUM  = 1'b0,
      OUTPUT = 1'b1
   } pack_state_t;

   // 3**k as a 64-bit constant; only ever evaluated at elaboration time.
   function automatic logic [63:0] pow3(input int k);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < k; i++) begin
         r = r * 64'd3;
      end
      return r;
   endfunction

endpackage

// File: rtl/s3_trit_mac.sv
// Adds trit * 3**cnt to an accumulator. Weights are a constant table built
// from pow3, and trit 2 is a shifted weight, so no multiplier is inferred.
// An encoding of 2'b11 contributes nothing.
import ntru_pkg::*;

module s3_trit_mac #(
   parameter int WORD_W = 8,
   parameter int N      = 5,
   parameter int CNT_W  = 3
) (
   input  logic [WORD_W-1:0] i_acc,
   input  trit_t             i_trit,
   input  logic [CNT_W-1:0]  i_cnt,
   output logic [WORD_W-1:0] o_acc
);

   logic [WORD_W-1:0] w_weights [2**CNT_W];
   logic [WORD_W-1:0] w_weight;

   // Table is padded to a power of two so every counter value indexes a real entry.
   for (genvar k = 0; k < 2**CNT_W; k++) begin : g_weights
      if (k < N) begin : g_used
         assign w_weights[k] = WORD_W'(pow3(k));
      end else begin : g_pad
         assign w_weights[k] = '0;
      end
   end

   // Select the weight for the current position and add 0, 1 or 2 times it.
   always_comb begin
      w_weight = w_weights[i_cnt];
      o_acc    = i_acc;
      case (i_trit)
         TRIT_ONE: o_acc = i_acc + w_weight;
         TRIT_TWO: o_acc = i_acc + (w_weight << 1);
         default:  o_acc = i_acc;
      endcase
   end

endmodule

// File: rtl/s3_pack.sv
// Streaming ternary-to-binary packer: folds TRITS_PER_WORD trits (first trit
// least significant) into one WORD_W-bit word, flushing early on trit_last.
// Optional feature macro S3_TRIT_CHECK_EN adds the sticky trit_err output that
// flags any accepted 2'b11 trit. WORD_W is limited to below 64.
import ntru_pkg::*;

module s3_pack #(
   parameter int TRITS_PER_WORD = 5,
   parameter int WORD_W         = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  trit_t             trit_in,
   input  logic              trit_valid,
   input  logic              trit_last,
   output logic              trit_ready,
   output logic [WORD_W-1:0] word_out,
   output logic              word_valid,
   output logic              word_last,
   input  logic              word_ready
`ifdef S3_TRIT_CHECK_EN
   ,output logic             trit_err
`endif
);

   localparam int CNT_W = (TRITS_PER_WORD > 1) ? $clog2(TRITS_PER_WORD) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TRITS_PER_WORD - 1);

   if ((pow3(TRITS_PER_WORD) - 64'd1) > ((64'd1 << WORD_W) - 64'd1)) begin : g_widthCheck
      $error("s3_pack: WORD_W too narrow for 3**TRITS_PER_WORD - 1");
   end

   pack_state_t       r_state, w_stateNext;
   logic [WORD_W-1:0] r_acc, w_accNext;
   logic [CNT_W-1:0]  r_cnt, w_cntNext;
   logic [WORD_W-1:0] r_word, w_wordNext;
   logic              r_valid, w_validNext;
   logic              r_last, w_lastNext;
   logic [WORD_W-1:0] w_mac;
   logic              w_accept;

   // In OUTPUT the accumulator and counter are always zero, so the same MAC
   // produces the t0 contribution of a trit accepted alongside the held word.
   s3_trit_mac #(
      .WORD_W (WORD_W),
      .N      (TRITS_PER_WORD),
      .CNT_W  (CNT_W)
   ) u_mac (
      .i_acc  (r_acc),
      .i_trit (trit_in),
      .i_cnt  (r_cnt),
      .o_acc  (w_mac)
   );

   assign trit_ready = (r_state == ACCUM) ? 1'b1 : word_ready;
   assign w_accept   = trit_valid & trit_ready;
   assign word_out   = r_word;
   assign word_valid = r_valid;
   assign word_last  = r_last;

   // Next-state logic: accumulate trits, emit a word when full or on last,
   // and hold it until the consumer takes it.
   always_comb begin
      w_stateNext = r_state;
      w_accNext   = r_acc;
      w_cntNext   = r_cnt;
      w_wordNext  = r_word;
      w_validNext = r_valid;
      w_lastNext  = r_last;
      case (r_state)
         ACCUM: begin
            if (w_accept) begin
               if ((r_cnt == CNT_LAST) || trit_last) begin
                  w_wordNext  = w_mac;
                  w_lastNext  = trit_last;
                  w_validNext = 1'b1;
                  w_accNext   = '0;
                  w_cntNext   = '0;
                  w_stateNext = OUTPUT;
               end else begin
                  w_accNext = w_mac;
                  w_cntNext = r_cnt + CNT_W'(1);
               end
            end
         end
         OUTPUT: begin
            if (word_ready) begin
               if (w_accept) begin
                  if ((TRITS_PER_WORD == 1) || trit_last) begin
                     w_wordNext  = w_mac;
                     w_lastNext  = trit_last;
                     w_validNext = 1'b1;
                  end else begin
                     w_accNext   = w_mac;
                     w_cntNext   = CNT_W'(1);
                     w_validNext = 1'b0;
                     w_stateNext = ACCUM;
                  end
               end else begin
                  w_validNext = 1'b0;
                  w_stateNext = ACCUM;
               end
            end
         end
         default: w_stateNext = ACCUM;
      endcase
   end

   // State and datapath registers; reset discards any partial or held word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ACCUM;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_word  <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
      end else begin
         r_state <= w_stateNext;
         r_acc   <= w_accNext;
         r_cnt   <= w_cntNext;
         r_word  <= w_wordNext;
         r_valid <= w_validNext;
         r_last  <= w_lastNext;
      end
   end

`ifdef S3_TRIT_CHECK_EN
   logic r_err;

   // Sticky flag for any accepted 2'b11 trit; only reset clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else if (w_accept && (trit_in == 2'b11)) begin
         r_err <= 1'b1;
      end
   end

   assign trit_err = r_err;
`endif

endmodule
